// File: rtl/mult_eval_sequencer.sv
// mult_eval_sequencer
// Exhaustive correctness sweep for one candidate combinational multiplier.
// Every operand pair is driven, held for SETTLE cycles, then the returned
// product is compared against the exact unsigned product. The sweep keeps a
// mismatch count and the first failing vector, which together form the
// correctness reward for the design-space search loop.

module mult_eval_sequencer #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [2*WIDTH-1:0]   prod,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 fail_valid,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [2*WIDTH-1:0]   fail_p
);

  // Vector index width: op_a occupies the upper half, op_b the lower half.
  localparam int IW = 2 * WIDTH;

  // Settle counter reload value; SETTLE is limited to 1..15, so 4 bits suffice.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  // Last vector of the sweep (all ones).
  localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Exact unsigned product, evaluated at the full 2*WIDTH result width so no
  // high-order bits are lost.
  function automatic logic [IW-1:0] exact_product(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [IW-1:0] wa;
    logic [IW-1:0] wb;
    wa = IW'(a);
    wb = IW'(b);
    return wa * wb;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;

  logic [IW-1:0]   idx_r;
  logic [3:0]      cnt_r;
  logic [IW:0]     err_count_r;
  logic            fail_valid_r;
  logic [WIDTH-1:0] fail_a_r;
  logic [WIDTH-1:0] fail_b_r;
  logic [IW-1:0]   fail_p_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;

  logic [IW-1:0]   idx_nxt_s;
  logic [3:0]      cnt_nxt_s;
  logic [IW:0]     err_count_nxt_s;
  logic            fail_valid_nxt_s;
  logic [WIDTH-1:0] fail_a_nxt_s;
  logic [WIDTH-1:0] fail_b_nxt_s;
  logic [IW-1:0]   fail_p_nxt_s;
  logic            busy_nxt_s;
  logic            done_nxt_s;
  logic            pass_nxt_s;

  logic            accept_s;
  logic            mismatch_s;
  logic [IW:0]     err_upd_s;
  logic [WIDTH-1:0] cur_a_s;
  logic [WIDTH-1:0] cur_b_s;

  assign cur_a_s = idx_r[IW-1:WIDTH];
  assign cur_b_s = idx_r[WIDTH-1:0];

  // A start is only accepted from IDLE and never together with abort.
  assign accept_s   = (state_r == IDLE) && start && !abort;

  // A vector fails when, in its compare cycle, the candidate disagrees with
  // the exact product. This still counts when abort arrives in that cycle.
  assign mismatch_s = (state_r == CHECK) &&
                      (prod != exact_product(cur_a_s, cur_b_s));

  // Error count including the current compare cycle; cannot overflow since
  // the maximum 2^(2W) fits in 2W+1 bits.
  assign err_upd_s  = err_count_r + {{IW{1'b0}}, mismatch_s};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision: sweep progression, completion and abort.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = CHECK;
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      CHECK: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (idx_r == IDX_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next values of the index, settle counter, results and status outputs.
  always_comb begin
    idx_nxt_s        = idx_r;
    cnt_nxt_s        = cnt_r;
    err_count_nxt_s  = err_count_r;
    fail_valid_nxt_s = fail_valid_r;
    fail_a_nxt_s     = fail_a_r;
    fail_b_nxt_s     = fail_b_r;
    fail_p_nxt_s     = fail_p_r;
    pass_nxt_s       = pass_r;
    case (state_r)
      IDLE: begin
        idx_nxt_s = {IW{1'b0}};
        if (accept_s) begin
          cnt_nxt_s        = SETTLE_INIT;
          err_count_nxt_s  = {(IW+1){1'b0}};
          fail_valid_nxt_s = 1'b0;
          fail_a_nxt_s     = {WIDTH{1'b0}};
          fail_b_nxt_s     = {WIDTH{1'b0}};
          fail_p_nxt_s     = {IW{1'b0}};
          pass_nxt_s       = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      DRIVE: begin
        if (abort) begin
          idx_nxt_s = {IW{1'b0}};
        end else if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      CHECK: begin
        err_count_nxt_s = err_upd_s;
        if (mismatch_s && !fail_valid_r) begin
          fail_valid_nxt_s = 1'b1;
          fail_a_nxt_s     = cur_a_s;
          fail_b_nxt_s     = cur_b_s;
          fail_p_nxt_s     = prod;
        end else begin
          fail_valid_nxt_s = fail_valid_r;
        end
        if (abort) begin
          idx_nxt_s = {IW{1'b0}};
        end else if (idx_r == IDX_LAST) begin
          pass_nxt_s = (err_upd_s == {(IW+1){1'b0}});
        end else begin
          idx_nxt_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
          cnt_nxt_s = SETTLE_INIT;
        end
      end
      DONE: begin
        idx_nxt_s = {IW{1'b0}};
      end
      default: begin
        idx_nxt_s = {IW{1'b0}};
      end
    endcase
    busy_nxt_s = (state_nxt_s == DRIVE) || (state_nxt_s == CHECK);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // Datapath and output registers; reset clears all progress and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r        <= {IW{1'b0}};
      cnt_r        <= 4'd0;
      err_count_r  <= {(IW+1){1'b0}};
      fail_valid_r <= 1'b0;
      fail_a_r     <= {WIDTH{1'b0}};
      fail_b_r     <= {WIDTH{1'b0}};
      fail_p_r     <= {IW{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      idx_r        <= idx_nxt_s;
      cnt_r        <= cnt_nxt_s;
      err_count_r  <= err_count_nxt_s;
      fail_valid_r <= fail_valid_nxt_s;
      fail_a_r     <= fail_a_nxt_s;
      fail_b_r     <= fail_b_nxt_s;
      fail_p_r     <= fail_p_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      pass_r       <= pass_nxt_s;
    end
  end

  assign op_a       = cur_a_s;
  assign op_b       = cur_b_s;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_count_r;
  assign fail_valid = fail_valid_r;
  assign fail_a     = fail_a_r;
  assign fail_b     = fail_b_r;
  assign fail_p     = fail_p_r;

endmodule

// File: tb/tb_mult_eval_sequencer.sv
// Self-checking bench for mult_eval_sequencer. Two instances (SETTLE=1 and
// SETTLE=3) share one behavioural candidate multiplier model whose mode
// selects correct, stuck-at-zero, bit0-inverted or 2-cycle-lag behaviour.
// Expected sweep results are pushed to a scoreboard queue before each sweep
// and popped when the sweep ends.

module tb_mult_eval_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, abort1, start3, abort3;
  logic [1:0] op_a1, op_b1, op_a3, op_b3;
  logic [3:0] prod1, prod3;
  logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
  logic [4:0] err1, err3;
  logic [1:0] fa1, fb1, fa3, fb3;
  logic [3:0] fp1, fp3;

  int mode;
  int cur_sel;
  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [4:0] err;
    logic       pass;
    logic       fv;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] fp;
    int         done_at;
  } exp_t;

  exp_t sb[$];

  mult_eval_sequencer #(.WIDTH(2), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .op_a(op_a1), .op_b(op_b1), .prod(prod1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_valid(fv1), .fail_a(fa1),
    .fail_b(fb1), .fail_p(fp1));

  mult_eval_sequencer #(.WIDTH(2), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .op_a(op_a3), .op_b(op_b3), .prod(prod3), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .fail_valid(fv3), .fail_a(fa3),
    .fail_b(fb3), .fail_p(fp3));

  // Candidate multiplier model.
  function automatic logic [3:0] cand(input int m, input logic [3:0] ex,
                                      input logic [3:0] lagged);
    case (m)
      0:       return ex;
      1:       return 4'd0;
      2:       return ex ^ 4'd1;
      3:       return lagged;
      default: return ex;
    endcase
  endfunction

  logic [3:0] ex1, ex3, lag1_a, lag1_b, lag3_a, lag3_b;
  assign ex1 = {2'b00, op_a1} * {2'b00, op_b1};
  assign ex3 = {2'b00, op_a3} * {2'b00, op_b3};

  // Two-stage pipeline giving the lagging candidate its 2-cycle delay.
  always @(posedge clk) begin
    lag1_a <= ex1;
    lag1_b <= lag1_a;
    lag3_a <= ex3;
    lag3_b <= lag3_a;
  end

  assign prod1 = cand(mode, ex1, lag1_b);
  assign prod3 = cand(mode, ex3, lag3_b);

  // Observed outputs of the instance currently under test.
  logic       c_busy, c_done, c_pass, c_fv;
  logic [4:0] c_err;
  logic [1:0] c_fa, c_fb, c_opa, c_opb;
  logic [3:0] c_fp;
  always_comb begin
    c_busy = busy1; c_done = done1; c_pass = pass1; c_fv = fv1; c_err = err1;
    c_fa = fa1; c_fb = fb1; c_fp = fp1; c_opa = op_a1; c_opb = op_b1;
    if (cur_sel == 3) begin
      c_busy = busy3; c_done = done3; c_pass = pass3; c_fv = fv3; c_err = err3;
      c_fa = fa3; c_fb = fb3; c_fp = fp3; c_opa = op_a3; c_opb = op_b3;
    end
  end

  // Reference result of a full sweep of the candidate in mode m.
  function automatic exp_t build_exp(input int m, input int settle);
    exp_t r;
    logic [1:0] a, b;
    logic [3:0] ex, got, prev;
    r.err = 5'd0; r.fv = 1'b0; r.fa = 2'd0; r.fb = 2'd0; r.fp = 4'd0;
    prev = 4'd0;
    for (int i = 0; i < 16; i++) begin
      a = 2'(i >> 2);
      b = 2'(i & 3);
      ex = {2'b00, a} * {2'b00, b};
      if (m == 3) got = (settle >= 2) ? ex : prev;
      else        got = cand(m, ex, 4'd0);
      if (got != ex) begin
        r.err = r.err + 5'd1;
        if (!r.fv) begin
          r.fv = 1'b1; r.fa = a; r.fb = b; r.fp = got;
        end
      end
      prev = ex;
    end
    r.pass = (r.err == 5'd0);
    r.done_at = (settle + 1) * 16;
    return r;
  endfunction

  task automatic set_start(input logic v);
    if (cur_sel == 3) start3 = v; else start1 = v;
  endtask

  task automatic set_abort(input logic v);
    if (cur_sel == 3) abort3 = v; else abort1 = v;
  endtask

  // Start a sweep, optionally abort or re-pulse start before given edges,
  // and observe done/busy for at most 'limit' edges after the start edge.
  task automatic run_sweep(input int abort_at, input int pulse_a,
                           input int pulse_b, input int limit,
                           output int done_edge, output int busy_cycles,
                           output int done_cycles);
    done_edge = -1; busy_cycles = 0; done_cycles = 0;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    if (c_busy) busy_cycles++;
    for (int e = 1; e <= limit; e++) begin
      if (e == abort_at) set_abort(1'b1);
      if (e == pulse_a || e == pulse_b) set_start(1'b1);
      @(posedge clk); #1;
      set_abort(1'b0);
      set_start(1'b0);
      if (c_done) begin
        done_cycles++;
        if (done_edge < 0) done_edge = e;
      end
      if (c_busy) busy_cycles++;
      if (done_edge >= 0 && e >= done_edge + 3) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    mode = 0; cur_sel = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, pass1, fv1, err1, fa1, fb1, fp1, op_a1, op_b1} !== 21'd0) begin
      $display("FAIL reset_s1 outputs got %b required 0",
               {busy1, done1, pass1, fv1, err1, fa1, fb1, fp1, op_a1, op_b1});
    end else passed++;
    checks++;
    if ({busy3, done3, pass3, fv3, err3, fa3, fb3, fp3, op_a3, op_b3} !== 21'd0) begin
      $display("FAIL reset_s3 outputs got %b required 0",
               {busy3, done3, pass3, fv3, err3, fa3, fb3, fp3, op_a3, op_b3});
    end else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full sweep of instance 'sel' in mode m, compared against the scoreboard.
  task automatic test_sweep(input string name, input int sel, input int m,
                            input int settle, input int pa, input int pb);
    int de, bc, dc;
    exp_t e;
    cur_sel = sel; mode = m;
    sb.push_back(build_exp(m, settle));
    repeat (3) @(negedge clk);
    run_sweep(-1, pa, pb, 20 * (settle + 1) * 16 / 4, de, bc, dc);
    e = sb.pop_front();
    checks++;
    if (de !== e.done_at) $display("FAIL %s done_edge got %0d required %0d", name, de, e.done_at);
    else passed++;
    checks++;
    if (c_err !== e.err) $display("FAIL %s err_count got %0d required %0d", name, c_err, e.err);
    else passed++;
    checks++;
    if (c_pass !== e.pass) $display("FAIL %s pass got %b required %b", name, c_pass, e.pass);
    else passed++;
    checks++;
    if ({c_fv, c_fa, c_fb, c_fp} !== {e.fv, e.fa, e.fb, e.fp})
      $display("FAIL %s first_fail got v%b a%0d b%0d p%0d required v%b a%0d b%0d p%0d",
               name, c_fv, c_fa, c_fb, c_fp, e.fv, e.fa, e.fb, e.fp);
    else passed++;
    checks++;
    if (bc !== e.done_at) $display("FAIL %s busy_cycles got %0d required %0d", name, bc, e.done_at);
    else passed++;
    checks++;
    if (dc !== 1) $display("FAIL %s done_cycles got %0d required 1", name, dc);
    else passed++;
    checks++;
    if ({c_opa, c_opb} !== 4'd0) $display("FAIL %s idle_ops got %0d required 0", name, {c_opa, c_opb});
    else passed++;
  endtask

  // Abort while checking vector 5: six vectors counted, no done, pass low.
  task automatic test_abort;
    int de, bc, dc;
    exp_t e;
    cur_sel = 1; mode = 2;
    e.err = 5'd6; e.pass = 1'b0; e.fv = 1'b1; e.fa = 2'd0; e.fb = 2'd0;
    e.fp = 4'd1; e.done_at = -1;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    run_sweep(12, -1, -1, 40, de, bc, dc);
    e = sb.pop_front();
    checks++;
    if (de !== e.done_at) $display("FAIL abort done_edge got %0d required %0d", de, e.done_at);
    else passed++;
    checks++;
    if (bc !== 12) $display("FAIL abort busy_cycles got %0d required 12", bc);
    else passed++;
    checks++;
    if ({c_err, c_pass} !== {e.err, e.pass})
      $display("FAIL abort partial got err%0d pass%b required err%0d pass%b", c_err, c_pass, e.err, e.pass);
    else passed++;
    checks++;
    if ({c_fv, c_fa, c_fb, c_fp} !== {e.fv, e.fa, e.fb, e.fp})
      $display("FAIL abort first_fail got v%b a%0d b%0d p%0d", c_fv, c_fa, c_fb, c_fp);
    else passed++;
  endtask

  // start together with abort in IDLE must be ignored.
  task automatic test_start_with_abort;
    cur_sel = 1;
    @(negedge clk);
    start1 = 1'b1; abort1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; abort1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy1 !== 1'b0) $display("FAIL start_with_abort busy got %b required 0", busy1);
    else passed++;
  endtask

  // Asynchronous reset in the middle of a sweep clears everything at once.
  task automatic test_reset_mid;
    int seen_done;
    cur_sel = 1; mode = 2;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (13) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, pass1, fv1, err1, fa1, fb1, fp1, op_a1, op_b1} !== 21'd0)
      $display("FAIL reset_mid outputs got %b required 0",
               {busy1, done1, pass1, fv1, err1, fa1, fb1, fp1, op_a1, op_b1});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy1 || done1) seen_done = 1;
    end
    checks++;
    if (seen_done !== 0) $display("FAIL reset_mid idle_after got activity required none");
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sweep("correct", 1, 0, 1, -1, -1);
    test_sweep("stuck_zero", 1, 1, 1, -1, -1);
    test_sweep("bit0_inv", 1, 2, 1, -1, -1);
    test_abort();
    test_sweep("after_abort", 1, 0, 1, -1, -1);
    test_sweep("restart_ignored", 1, 2, 1, 5, 20);
    test_start_with_abort();
    test_sweep("lag_settle3", 3, 3, 3, -1, -1);
    test_sweep("lag_settle1", 1, 3, 1, -1, -1);
    checks++;
    if (err1 === 5'd0) $display("FAIL lag_settle1_nonzero err_count got %0d required >0", err1);
    else passed++;
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
